// File: rtl/if_stage.sv
// Instruction-fetch stage for the miniRV single-cycle core: holds the PC, fetches one
// word per step over a req/ready handshake and selects the next PC from npc_op.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  npc_op_i,
  input  logic        br_taken_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] alu_c_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o,
  output logic        misalign_o,
  output logic [31:0] instret_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_JAL  = 2'b01;
  localparam logic [1:0] NPC_BR   = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  state_e           state_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  inst_q;
  logic [XLEN-1:0]  instret_q;
  logic             misalign_q;
  logic [XLEN-1:0]  pc4_d;
  logic [XLEN-1:0]  pc_imm_d;
  logic [XLEN-1:0]  npc_d;

  // Next-PC candidates; all adds wrap modulo 2^32.
  always_comb begin
    pc4_d    = pc_q + XLEN'(4);
    pc_imm_d = pc_q + imm_i;
    npc_d    = pc4_d;
    unique case (npc_op_i)
      NPC_PC4:  npc_d = pc4_d;
      NPC_JAL:  npc_d = pc_imm_d;
      NPC_BR:   npc_d = br_taken_i ? pc_imm_d : pc4_d;
      NPC_JALR: npc_d = {alu_c_i[XLEN-1:1], 1'b0};
      default:  npc_d = pc4_d;
    endcase
  end

  // Fetch/execute sequencer; rst overrides every transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      instret_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (imem_ready_i) begin
            inst_q  <= imem_rdata_i;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (npc_d[1:0] == 2'b00) begin
            pc_q      <= npc_d;
            instret_q <= instret_q + XLEN'(1);
            state_q   <= S_FETCH;
          end else begin
            misalign_q <= 1'b1;
            state_q    <= S_HALT;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req_o   = (state_q == S_FETCH);
  assign inst_valid_o = (state_q == S_EXEC);
  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_q;
  assign pc4_o        = pc4_d;
  assign misalign_o   = misalign_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized directed bench for if_stage against a transaction-level fetch/execute model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [31:0] imm;
  logic [31:0] alu_c;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic [31:0] exp_ret;
  logic        exp_mis;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .npc_op_i     (npc_op),
    .br_taken_i   (br_taken),
    .imm_i        (imm),
    .alu_c_i      (alu_c),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_ready_i (imem_ready),
    .imem_rdata_i (imem_rdata),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .pc_o         (pc),
    .pc4_o        (pc4),
    .misalign_o   (misalign),
    .instret_o    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference next PC from the ISA rules, before the alignment check.
  function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [1:0] op,
                                             input logic br, input logic [31:0] im,
                                             input logic [31:0] alu);
    if (op == 2'd3) return alu & 32'hFFFF_FFFE;
    if (op == 2'd1 || (op == 2'd2 && br)) return p + im;
    return p + 32'd4;
  endfunction

  task automatic chk_idle();
    chk("idle_req",      32'(imem_req),   32'd0);
    chk("idle_valid",    32'(inst_valid), 32'd0);
    chk("idle_pc",       pc,              exp_pc);
    chk("idle_pc4",      pc4,             exp_pc + 32'd4);
    chk("idle_inst",     inst,            exp_inst);
    chk("idle_instret",  instret,         exp_ret);
    chk("idle_misalign", 32'(misalign),   32'(exp_mis));
  endtask

  // Apply reset for one edge; on return the bench sits in the cycle after IDLE.
  task automatic do_reset();
    rst        = 1'b1;
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    @(negedge clk);
    rst      = 1'b0;
    exp_pc   = RESET_PC;
    exp_inst = 32'h0;
    exp_ret  = 32'h0;
    exp_mis  = 1'b0;
    chk_idle();
    @(negedge clk);
  endtask

  // One instruction: `waits` not-ready FETCH cycles, then EXEC with the given controls.
  task automatic fetch_exec(input int waits, input logic [1:0] op, input logic br,
                            input logic [31:0] im, input logic [31:0] alu);
    logic [31:0] word;
    logic [31:0] tgt;
    word = $urandom;
    for (int w = 0; w <= waits; w++) begin
      chk("fetch_req",     32'(imem_req),   32'd1);
      chk("fetch_addr",    imem_addr,       exp_pc);
      chk("fetch_valid",   32'(inst_valid), 32'd0);
      chk("fetch_inst",    inst,            exp_inst);
      chk("fetch_instret", instret,         exp_ret);
      imem_ready = (w == waits);
      imem_rdata = (w == waits) ? word : $urandom;
      npc_op     = 2'($urandom);
      @(negedge clk);
    end
    exp_inst = word;
    chk("exec_valid", 32'(inst_valid), 32'd1);
    chk("exec_req",   32'(imem_req),   32'd0);
    chk("exec_inst",  inst,            exp_inst);
    chk("exec_pc",    pc,              exp_pc);
    chk("exec_pc4",   pc4,             exp_pc + 32'd4);
    npc_op     = op;
    br_taken   = br;
    imm        = im;
    alu_c      = alu;
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    tgt = ref_target(exp_pc, op, br, im, alu);
    @(negedge clk);
    if (tgt % 4 != 0) exp_mis = 1'b1;
    else begin
      exp_pc  = tgt;
      exp_ret = exp_ret + 32'd1;
    end
    chk("post_misalign", 32'(misalign), 32'(exp_mis));
    chk("post_pc",       pc,            exp_pc);
  endtask

  task automatic chk_halt(input int n);
    for (int i = 0; i < n; i++) begin
      chk("halt_req",      32'(imem_req),   32'd0);
      chk("halt_valid",    32'(inst_valid), 32'd0);
      chk("halt_pc",       pc,              exp_pc);
      chk("halt_inst",     inst,            exp_inst);
      chk("halt_instret",  instret,         exp_ret);
      chk("halt_misalign", 32'(misalign),   32'd1);
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      npc_op     = 2'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; npc_op = 2'd0; br_taken = 1'b0; imm = '0; alu_c = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    exp_pc = RESET_PC; exp_inst = '0; exp_ret = '0; exp_mis = 1'b0;
    repeat (2) @(negedge clk);

    // Back-to-back sequential instructions with ready always high.
    do_reset();
    repeat (3) fetch_exec(0, 2'd0, 1'b0, 32'h0, 32'h0);
    chk("three_retired", instret, 32'd3);

    // Three wait cycles in FETCH.
    fetch_exec(3, 2'd0, 1'b0, 32'h0, 32'h0);

    // Control flow around 0x100 with a negative immediate.
    fetch_exec(0, 2'd1, 1'b0, 32'h100 - exp_pc, 32'h0);
    fetch_exec(0, 2'd2, 1'b1, 32'hFFFF_FFF0, 32'h0);
    chk("br_taken_pc", pc, 32'h0000_00F0);
    fetch_exec(1, 2'd1, 1'b0, 32'h10, 32'h0);
    fetch_exec(0, 2'd2, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("br_not_taken_pc", pc, 32'h0000_0104);
    fetch_exec(0, 2'd1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    fetch_exec(2, 2'd1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    chk("jal_pc", pc, 32'h0000_00F0);
    fetch_exec(0, 2'd3, 1'b0, 32'h0, 32'h0000_0201);
    chk("jalr_bit0_pc", pc, 32'h0000_0200);

    // Random aligned control flow.
    for (int i = 0; i < 40; i++)
      fetch_exec($urandom_range(0, 2), 2'($urandom_range(0, 3)), 1'($urandom),
                 $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFD);

    // Reset during a FETCH wait at 0x40.
    fetch_exec(0, 2'd3, 1'b0, 32'h0, 32'h0000_0040);
    chk("wait_addr", imem_addr, 32'h0000_0040);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("wait_req", 32'(imem_req), 32'd1);
    do_reset();
    fetch_exec(0, 2'd0, 1'b0, 32'h0, 32'h0);
    chk("post_reset_instret", instret, 32'd1);

    // PC wrap at the top of the address space.
    fetch_exec(0, 2'd3, 1'b0, 32'h0, 32'hFFFF_FFFC);
    fetch_exec(0, 2'd0, 1'b0, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_misalign", 32'(misalign), 32'd0);

    // Misaligned jalr target halts the stage.
    fetch_exec(1, 2'd3, 1'b0, 32'h0, 32'h0000_0202);
    chk("halt_flag", 32'(misalign), 32'd1);
    chk_halt(5);

    // Recovery from HALT.
    do_reset();
    fetch_exec(1, 2'($urandom_range(0, 2)), 1'($urandom), $urandom & 32'hFFFF_FFFC, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the miniRV single-cycle core. It holds the program counter, fetches one instruction per step from instruction memory over a request/ready handshake, and presents it to the instruction decoder. On the execute cycle it applies the decoder's `npc_op` to select the next PC. It sits directly upstream of the decoder and drives `inst`, `pc` and `pc4` into the datapath.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be word-aligned.
- `clk` input 1: single clock. All registers update on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `npc_op` input 2: next-PC select from the decoder.
  - 00: PC+4.
  - 01: jal, PC+imm.
  - 10: branch, PC+imm if `br_taken`, else PC+4.
  - 11: jalr, `alu_c` with bit 0 cleared.
- `br_taken` input 1: branch comparator result, qualified by the decoder's `br_op`.
- `imm` input 32: sign-extended immediate.
- `alu_c` input 32: ALU result, used as the jalr target.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch byte address; equals `pc`.
- `imem_ready` input 1: memory has valid data on `imem_rdata` this cycle.
- `imem_rdata` input 32: fetched instruction word.
- `inst` output 32: latched instruction, to the decoder.
- `inst_valid` output 1: high only during EXEC. The datapath gates `rf_we` and `ram_we` with it.
- `pc` output 32: PC of `inst`.
- `pc4` output 32: `pc`+4, used for the `rf_wsel`=10 writeback.
- `misalign` output 1: sticky flag, set when a computed next PC has bits [1:0] not equal to 00.
- `instret` output 32: count of retired instructions.

## Operation
- The FSM has four states: IDLE, FETCH, EXEC, HALT.
- Reset values:
  - state=IDLE, pc=RESET_PC, inst=32'h0, misalign=0, instret=0.
  - inst=0 decodes to the all-inactive control word (no register write, no RAM write, npc_op=00).
- IDLE: lasts exactly one cycle, then goes to FETCH.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`; both are held stable until accepted.
  - On a rising edge with `imem_ready`=1: inst <= `imem_rdata`, then go to EXEC.
  - Otherwise stay in FETCH.
- EXEC:
  - `inst_valid`=1 and `imem_req`=0.
  - The decoder and datapath evaluate combinationally during this cycle.
  - At the closing edge the stage computes npc from `npc_op`.
  - If npc[1:0]=00: pc <= npc, instret <= instret+1, go to FETCH.
  - Otherwise: misalign <= 1, pc holds, instret holds, go to HALT.
- HALT: `imem_req`=0, `inst_valid`=0. The stage stays here until `rst`.
- `imem_req` and `inst_valid` are decoded combinationally from the state register.
- `imem_ready` is ignored outside FETCH.
- Arithmetic rules:
  - All adds are 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0, with no flag.
  - instret wraps from 32'hFFFF_FFFF to 0.
- `inst` holds its last value in FETCH and HALT. `pc4` is always `pc`+4.
- A jalr target with bit 1 set raises misalign after bit 0 is cleared.

## Timing
- Reset is released before edge 0.
  - Cycle 0: IDLE.
  - Cycle 1: FETCH, with the request visible.
- The earliest acceptance is the edge that closes cycle 1, provided `imem_ready`=1 in cycle 1. EXEC is then cycle 2.
- Minimum throughput is 2 cycles per instruction (FETCH+EXEC). Each wait cycle with `imem_ready`=0 adds one cycle.
- `rst`=1 at any edge, in any state, overrides every transition. The next cycle is IDLE with all reset values, including mid-fetch.
- An in-flight memory response after reset is ignored. The memory is not cancelled.
- `pc` changes only at the edge that closes an EXEC cycle.

## Test plan
- Reset with RESET_PC=0, `imem_ready` tied to 1:
  - Cycle 1 shows `imem_req`=1 and `imem_addr`=0.
  - Cycle 2 shows `inst_valid`=1.
  - Cycle 3 shows `imem_addr`=4.
  - Three instructions retire in 7 cycles with `instret`=3.
- FETCH with `imem_ready` low for 3 cycles: `imem_addr` is stable for all 4 FETCH cycles; `inst` updates only on the ready edge.
- At `pc`=0x100, `imm`=0xFFFF_FFF0:
  - `npc_op`=10, `br_taken`=1 -> next fetch at 0xF0.
  - `br_taken`=0 -> next fetch at 0x104.
  - `npc_op`=01 -> 0xF0.
- `npc_op`=11 with `alu_c`=0x201 -> next fetch at 0x200.
- `npc_op`=11 with `alu_c`=0x202 -> misalign=1, HALT, `imem_req` stays 0, `pc` holds.
- `rst` pulsed during a FETCH wait at `pc`=0x40 -> the next cycle is IDLE with `pc`=RESET_PC and `inst`=0; `instret`=0, then a normal fetch follows.
- `pc`=0xFFFF_FFFC with `npc_op`=00 -> next `pc`=0 and misalign stays 0.
